// File: rtl/burst_ram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : burst_ram_responder_pkg
//  Description : Shared command codes and FSM state encoding for the
//                BurstRAM responder.
//  Revision    : 1.0  initial release
// ============================================================================
package burst_ram_responder_pkg;

    // Command codes carried on br_cmd
    localparam logic BR_CMD_READ  = 1'b0;
    localparam logic BR_CMD_WRITE = 1'b1;

    // One-hot responder states
    typedef enum logic [4:0] {
        ST_INIT        = 5'b00001,
        ST_IDLE        = 5'b00010,
        ST_READ_WAIT   = 5'b00100,
        ST_READ_BURST  = 5'b01000,
        ST_WRITE_BURST = 5'b10000
    } br_state_e;

endpackage
`default_nettype wire

// File: rtl/burst_ram_array.sv
`default_nettype none
// ============================================================================
//  Module      : burst_ram_array
//  Description : Single-port synchronous RAM with registered read and
//                per-byte write enables (read-first on a shared address).
//  Revision    : 1.0  initial release
// ============================================================================
module burst_ram_array #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   we_bytes,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Byte-masked write and registered read of the addressed word
    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (we_bytes[b]) begin
                r_mem[addr][b*8 +: 8] <= din[b*8 +: 8];
            end
        end
        dout <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/burst_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : burst_ram_responder
//  Description : Responder end of the BurstRAM interface. Accepts one-cycle
//                read/write burst commands, returns read beats after a fixed
//                latency and absorbs byte-masked write beats.
//  Revision    : 1.0  initial release
// ============================================================================
module burst_ram_responder
    import burst_ram_responder_pkg::*;
#(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_COUNT    = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int READ_LATENCY            = 2,
    parameter int INIT_CYCLES             = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 br_cmd,
    input  logic                                 br_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    output logic                                 br_rd_data_valid,
    output logic                                 br_busy,
    output logic                                 br_cmd_err
);

    localparam int AW     = RAM_DEPTH_BITWIDTH;
    localparam int DW     = RAM_BURST_DATA_BITWIDTH;
    localparam int BYTES  = DW / 8;
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);
    localparam int BEAT_W = $clog2(RAM_BURST_DATA_COUNT + 1);
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);

    // With latency >= 2 the beat passes through the RAM output register and
    // then the br_rd_data register, so RAM fetches lead the beats by two
    // cycles; FETCH_SKEW is how long after acceptance the first fetch happens.
    localparam int FETCH_SKEW = (READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0;

    // The shared address register runs every cycle from acceptance, so a read
    // preloads it such that it reaches the burst start exactly at the first
    // fetch. Negative offsets wrap modulo the array depth.
    localparam logic [AW-1:0] ADDR_ONE      = AW'(1);
    localparam logic [AW-1:0] READ_ADDR_ADJ = AW'(1 - FETCH_SKEW);

    br_state_e         r_state;
    logic [INIT_W-1:0] r_init_cnt;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [AW-1:0]     r_addr;
    logic              r_busy;
    logic              r_valid;
    logic              r_err;

    logic [AW-1:0]     w_ram_addr;
    logic [BYTES-1:0]  w_we_bytes;
    logic [DW-1:0]     w_ram_dout;
    logic              w_load_data;

    // RAM port steering: the command cycle uses br_addr directly so beat 0 of
    // a write commits at the accepting edge; later cycles use r_addr.
    always_comb begin
        w_ram_addr  = (r_state == ST_IDLE) ? br_addr : r_addr;
        w_we_bytes  = '0;
        if (!rst && (((r_state == ST_IDLE) && br_cmd_en && (br_cmd == BR_CMD_WRITE))
                     || (r_state == ST_WRITE_BURST))) begin
            w_we_bytes = ~br_data_mask;
        end
        w_load_data = ((r_state == ST_READ_WAIT) && (r_lat_cnt == '0))
                   || ((r_state == ST_READ_BURST) && (r_beat_cnt != BEAT_W'(1)));
    end

    burst_ram_array #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) u_array (
        .clk      (clk),
        .addr     (w_ram_addr),
        .we_bytes (w_we_bytes),
        .din      (br_wr_data),
        .dout     (w_ram_dout)
    );

    // Responder FSM with registered busy / valid / error outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= INIT_W'(INIT_CYCLES - 1);
            r_lat_cnt  <= '0;
            r_beat_cnt <= '0;
            r_addr     <= '0;
            r_busy     <= 1'b1;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= br_cmd_en && r_busy;
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_init_cnt <= r_init_cnt - INIT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (br_cmd_en) begin
                        if (br_cmd == BR_CMD_WRITE) begin
                            r_addr <= br_addr + ADDR_ONE;
                            // A single-beat write completes in the command cycle
                            if (RAM_BURST_DATA_COUNT > 1) begin
                                r_state    <= ST_WRITE_BURST;
                                r_busy     <= 1'b1;
                                r_beat_cnt <= BEAT_W'(RAM_BURST_DATA_COUNT - 1);
                            end
                        end else begin
                            r_addr <= br_addr + READ_ADDR_ADJ;
                            r_busy <= 1'b1;
                            if (READ_LATENCY == 1) begin
                                r_state    <= ST_READ_BURST;
                                r_valid    <= 1'b1;
                                r_beat_cnt <= BEAT_W'(RAM_BURST_DATA_COUNT);
                            end else begin
                                r_state   <= ST_READ_WAIT;
                                r_lat_cnt <= LAT_W'(READ_LATENCY - 2);
                            end
                        end
                    end
                end
                ST_READ_WAIT: begin
                    r_addr <= r_addr + ADDR_ONE;
                    if (r_lat_cnt == '0) begin
                        r_state    <= ST_READ_BURST;
                        r_valid    <= 1'b1;
                        r_beat_cnt <= BEAT_W'(RAM_BURST_DATA_COUNT);
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end
                ST_READ_BURST: begin
                    r_addr <= r_addr + ADDR_ONE;
                    if (r_beat_cnt == BEAT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_beat_cnt <= r_beat_cnt - BEAT_W'(1);
                    end
                end
                ST_WRITE_BURST: begin
                    r_addr <= r_addr + ADDR_ONE;
                    if (r_beat_cnt == BEAT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_beat_cnt <= r_beat_cnt - BEAT_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_INIT;
                    r_init_cnt <= INIT_W'(INIT_CYCLES - 1);
                    r_busy     <= 1'b1;
                    r_valid    <= 1'b0;
                end
            endcase
        end
    end

    if (READ_LATENCY >= 2) begin : g_out_reg
        logic [DW-1:0] r_rd_data;

        // Capture the fetched word one cycle ahead of each beat; holds otherwise
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_data <= '0;
            end else if (w_load_data) begin
                r_rd_data <= w_ram_dout;
            end
        end

        assign br_rd_data = r_rd_data;
    end else begin : g_out_direct
        logic [DW-1:0] r_hold;

        // At unit latency the RAM output register is the beat register; keep
        // a copy so the last beat stays visible after the burst.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_hold <= '0;
            end else if (r_valid) begin
                r_hold <= w_ram_dout;
            end
        end

        assign br_rd_data = r_valid ? w_ram_dout : r_hold;
    end

    assign br_rd_data_valid = r_valid;
    assign br_busy          = r_busy;
    assign br_cmd_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_burst_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_burst_ram_responder
//  Description : Directed self-checking bench for burst_ram_responder with
//                default parameters (16 x 64-bit, 4 beats, latency 2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_burst_ram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_cmd;
    logic        br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;
    logic        br_busy;
    logic        br_cmd_err;

    int checks = 0;
    int errors = 0;

    burst_ram_responder #(
        .RAM_DEPTH_BITWIDTH      (4),
        .RAM_BURST_DATA_COUNT    (4),
        .RAM_BURST_DATA_BITWIDTH (64),
        .READ_LATENCY            (2),
        .INIT_CYCLES             (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy),
        .br_cmd_err       (br_cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with busy low; beat k is driven during cycle T+k
    task automatic wr_burst(input logic [3:0] a, input logic [3:0][63:0] d,
                            input logic [3:0][7:0] m, input string tag);
        br_cmd_en    = 1'b1;
        br_cmd       = 1'b1;
        br_addr      = a;
        br_wr_data   = d[0];
        br_data_mask = m[0];
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            br_cmd_en    = 1'b0;
            br_wr_data   = d[k];
            br_data_mask = m[k];
            if (k == 1) chk({tag, "_busy_hi"}, 64'(br_busy), 64'd1);
        end
        @(negedge clk);
        br_wr_data   = '0;
        br_data_mask = '1;
        chk({tag, "_busy_lo"}, 64'(br_busy), 64'd0);
    endtask

    // Called at a negedge with busy low; optional illegal write at T+1
    task automatic rd_burst(input logic [3:0] a, input logic [3:0][63:0] e,
                            input logic poke, input string tag);
        br_cmd_en = 1'b1;
        br_cmd    = 1'b0;
        br_addr   = a;
        @(negedge clk);
        br_cmd_en = 1'b0;
        chk({tag, "_busy_t1"}, 64'(br_busy), 64'd1);
        chk({tag, "_valid_t1"}, 64'(br_rd_data_valid), 64'd0);
        if (poke) begin
            br_cmd_en    = 1'b1;
            br_cmd       = 1'b1;
            br_addr      = a;
            br_wr_data   = 64'hAAAA_AAAA_AAAA_AAAA;
            br_data_mask = 8'h00;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            br_cmd_en    = 1'b0;
            br_data_mask = '1;
            chk($sformatf("%s_valid_b%0d", tag, k), 64'(br_rd_data_valid), 64'd1);
            chk($sformatf("%s_data_b%0d", tag, k), br_rd_data, e[k]);
            if (poke && k == 0) chk({tag, "_err_pulse"}, 64'(br_cmd_err), 64'd1);
            if (poke && k == 1) chk({tag, "_err_clear"}, 64'(br_cmd_err), 64'd0);
        end
        @(negedge clk);
        chk({tag, "_valid_end"}, 64'(br_rd_data_valid), 64'd0);
        chk({tag, "_busy_end"}, 64'(br_busy), 64'd0);
        chk({tag, "_data_hold"}, br_rd_data, e[3]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        br_cmd       = 1'b0;
        br_cmd_en    = 1'b0;
        br_addr      = '0;
        br_wr_data   = '0;
        br_data_mask = '1;

        // Reset held for three clock edges
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(br_busy), 64'd1);
        chk("rst_valid", 64'(br_rd_data_valid), 64'd0);
        chk("rst_data", br_rd_data, 64'd0);
        chk("rst_err", 64'(br_cmd_err), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("init_busy_%0d", i), 64'(br_busy), 64'd1);
            chk($sformatf("init_valid_%0d", i), 64'(br_rd_data_valid), 64'd0);
        end
        @(negedge clk);
        chk("init_done", 64'(br_busy), 64'd0);

        // Byte mask: clear words 0..3, then write low half of word 0 only
        wr_burst(4'd0, {64'd0, 64'd0, 64'd0, 64'd0}, {8'h00, 8'h00, 8'h00, 8'h00}, "clr");
        wr_burst(4'd0, {64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF},
                 {8'hFF, 8'hFF, 8'hFF, 8'hF0}, "mask_wr");
        rd_burst(4'd0, {64'd0, 64'd0, 64'd0, 64'h0000_0000_FFFF_FFFF}, 1'b0, "mask_rd");

        // Plain write then read at address 2
        wr_burst(4'd2, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                 {8'h00, 8'h00, 8'h00, 8'h00}, "wr2");
        rd_burst(4'd2, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0, "rd2");

        // Wrap at the top of the array; read issued right as busy falls
        wr_burst(4'd14, {64'd4, 64'd3, 64'd2, 64'd1}, {8'h00, 8'h00, 8'h00, 8'h00}, "wr14");
        rd_burst(4'd14, {64'd4, 64'd3, 64'd2, 64'd1}, 1'b0, "rd14");
        rd_burst(4'd0, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 64'd4, 64'd3},
                 1'b0, "rd0_wrap");

        // Command while busy is flagged and ignored
        rd_burst(4'd2, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b1, "viol");
        rd_burst(4'd2, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0, "viol_after");

        // Reset asserted during beat 2 of a read
        br_cmd_en = 1'b1;
        br_cmd    = 1'b0;
        br_addr   = 4'd14;
        @(negedge clk);
        br_cmd_en = 1'b0;
        @(negedge clk);
        chk("mid_b0", br_rd_data, 64'd1);
        @(negedge clk);
        chk("mid_b1", br_rd_data, 64'd2);
        @(negedge clk);
        chk("mid_b2_valid", 64'(br_rd_data_valid), 64'd1);
        chk("mid_b2", br_rd_data, 64'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", 64'(br_rd_data_valid), 64'd0);
        chk("mid_rst_busy", 64'(br_busy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mid_init_busy_%0d", i), 64'(br_busy), 64'd1);
            chk($sformatf("mid_init_valid_%0d", i), 64'(br_rd_data_valid), 64'd0);
        end
        @(negedge clk);
        chk("mid_init_done", 64'(br_busy), 64'd0);
        rd_burst(4'd14, {64'd4, 64'd3, 64'd2, 64'd1}, 1'b0, "post_rst14");
        rd_burst(4'd2, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0, "post_rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
